// File: rtl/seq_mult_pkg.sv
// Shared definitions for the seq_mult_n shift-and-add multiplier.
// Optional build macro: SEQ_MULT_EARLY_EXIT_EN (see seq_mult_n.sv).
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_CALC = CALC;
    localparam logic [1:0] ST_DONE = DONE;

endpackage

// File: rtl/rca_adder_n.sv
// N-bit ripple-carry adder; each bit is one full-adder cell on the carry chain.
module rca_adder_n #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end

    assign cout = carry[N];

endmodule

// File: rtl/seq_mult_n.sv
// Sequential unsigned multiplier, one partial product per clock.
// Define SEQ_MULT_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
//
// state | meaning
// IDLE  | waiting for start, operands captured on accept
// CALC  | one shift-and-add iteration per edge
// DONE  | single-cycle done pulse, p valid
module seq_mult_n
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]    acc;
    logic [CW-1:0]    count;

    logic [PW-1:0]    addend;
    logic [PW-1:0]    acc_next;
    logic [WIDTH-1:0] mplier_next;
    logic             add_cout;
    logic             last_iter;

    assign addend      = mplier[0] ? mcand : '0;
    assign mplier_next = mplier >> 1;

    // Carry-out is always zero: the product of two WIDTH-bit values fits in 2*WIDTH bits.
    rca_adder_n #(.N(PW)) u_adder (
        .a    (acc),
        .b    (addend),
        .cin  (1'b0),
        .sum  (acc_next),
        .cout (add_cout)
    );

`ifdef SEQ_MULT_EARLY_EXIT_EN
    assign last_iter = (mplier_next == '0) || (count == LAST);
`else
    assign last_iter = (count == LAST);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            p      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, a};
                        mplier <= b;
                        acc    <= '0;
                        count  <= '0;
                        state  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier_next;
                    count  <= count + 1'b1;
                    if (last_iter) begin
                        p     <= acc_next;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == ST_CALC) || (state == ST_DONE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_seq_mult_n.sv
// Directed bench for seq_mult_n with WIDTH=4 and WIDTH=8 instances.
// Expected latencies follow SEQ_MULT_EARLY_EXIT_EN when it is defined.
module tb_seq_mult_n;

    logic       clk;
    logic       reset;
    logic       start4, start8;
    logic [3:0] a4, b4;
    logic [7:0] a8, b8;
    logic       busy4, done4, busy8, done8;
    logic [7:0] p4;
    logic [15:0] p8;

    int checks = 0;
    int errors = 0;

    seq_mult_n #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .p(p4)
    );

    seq_mult_n #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .p(p8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic s, input int aa, input int bb);
        if (w == 8) begin
            start8 = s; a8 = aa[7:0]; b8 = bb[7:0];
        end else begin
            start4 = s; a4 = aa[3:0]; b4 = bb[3:0];
        end
    endtask

    function automatic logic get_busy(input int w);
        return (w == 8) ? busy8 : busy4;
    endfunction

    function automatic logic get_done(input int w);
        return (w == 8) ? done8 : done4;
    endfunction

    function automatic logic [31:0] get_p(input int w);
        return (w == 8) ? {16'd0, p8} : {24'd0, p4};
    endfunction

    // One operation: accept, then watch every cycle until done (bounded).
    task automatic op(input string tag, input int w, input int aa, input int bb,
                      input int expp, input int lat, input int hold, input bit repulse);
        int  k;
        bit  seen;
        seen = 0;
        k    = 0;
        @(negedge clk);
        drive(w, 1'b1, aa, bb);
        @(negedge clk);
        drive(w, 1'b0, ~aa, ~bb);
        chk({tag, "_busy_first"}, get_busy(w), 1'b1);
        while (!seen && k < 30) begin
            @(negedge clk);
            k++;
            if (repulse && k == 1) drive(w, 1'b1, 7, 7);
            if (repulse && k == 2) drive(w, 1'b0, 0, 0);
            if (get_done(w)) begin
                seen = 1;
                chk({tag, "_latency"}, k, lat);
                chk({tag, "_p"}, get_p(w), expp);
                chk({tag, "_busy_done"}, get_busy(w), 1'b1);
            end else begin
                chk({tag, "_busy_calc"}, get_busy(w), 1'b1);
                chk({tag, "_p_hold"}, get_p(w), hold);
            end
        end
        if (!seen) chk({tag, "_timeout"}, 1'b0, 1'b1);
        @(negedge clk);
        chk({tag, "_done_pulse"}, get_done(w), 1'b0);
        chk({tag, "_busy_idle"}, get_busy(w), 1'b0);
        chk({tag, "_p_after"}, get_p(w), expp);
    endtask

`ifdef SEQ_MULT_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    initial begin
        reset = 1'b1;
        drive(4, 1'b0, 0, 0);
        drive(8, 1'b0, 0, 0);
        repeat (2) @(negedge clk);
        chk("rst_busy4", busy4, 1'b0);
        chk("rst_done4", done4, 1'b0);
        chk("rst_p4", p4, 8'h00);
        chk("rst_busy8", busy8, 1'b0);
        chk("rst_p8", p8, 16'h0000);
        reset = 1'b0;

        op("t1", 4, 3, 5, 8'h0F, EE ? 3 : 4, 0, 1'b0);
        op("t2a", 4, 15, 15, 8'hE1, 4, 8'h0F, 1'b0);
        op("t2b", 4, 1, 1, 8'h01, EE ? 1 : 4, 8'hE1, 1'b0);
        op("t3", 4, 9, 0, 8'h00, EE ? 1 : 4, 8'h01, 1'b0);
        op("t4", 4, 3, 5, 8'h0F, EE ? 3 : 4, 8'h00, 1'b1);
        @(negedge clk);
        chk("t4_no_restart", busy4, 1'b0);

        // Reset lands on the second CALC edge of a 6*7 operation.
        @(negedge clk);
        drive(4, 1'b1, 6, 7);
        @(negedge clk);
        drive(4, 1'b0, 0, 0);
        chk("t5_busy_calc", busy4, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t5_busy_rst", busy4, 1'b0);
        chk("t5_done_rst", done4, 1'b0);
        chk("t5_p_rst", p4, 8'h00);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t5_no_done", done4, 1'b0);
        end
        op("t5b", 4, 2, 6, 8'h0C, EE ? 3 : 4, 8'h00, 1'b0);

        op("t6", 8, 255, 2, 16'h01FE, EE ? 2 : 8, 16'h0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_mult_n.md
Name: seq_mult_n

Overview:
- Parametrised sequential unsigned multiplier. Successor to the fixed combinational multiply-by-constant blocks.
- Computes p = a * b for WIDTH-bit operands with a shift-and-add datapath: one partial product per clock through a 2*WIDTH ripple-carry adder.
- Sits between switch/register inputs and display/result logic in lab top levels.
- Uses a start/busy/done handshake so the caller can sequence operations.

Parameters:
- WIDTH, 4, operand width in bits (legal 2..16); product width is 2*WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  multiplicand, unsigned; captured when start is accepted
- b  input  WIDTH  multiplier, unsigned; captured when start is accepted
- busy  output  1  high while in CALC or DONE
- done  output  1  one-cycle pulse; p is valid from this cycle
- p  output  2*WIDTH  registered product; held until the next accepted start completes

Behaviour:
- Reset:
  - Reset high at a clock edge → state IDLE; acc, mcand, mplier, count and p cleared to 0; busy=0, done=0.
  - Reset dominates start and any in-flight operation. The aborted operation never pulses done, and p reads 0.
- Registers: mcand (2*WIDTH), mplier (WIDTH), acc (2*WIDTH), count ($clog2(WIDTH+1)), p (2*WIDTH), state.
- FSM states: IDLE, CALC, DONE.
  - IDLE:
    - busy=0, done=0.
    - On start=1: mcand←{WIDTH zeros, a}; mplier←b; acc←0; count←0; go to CALC.
    - On start=0: stay in IDLE.
  - CALC, per edge:
    - If mplier[0]=1: acc←acc+mcand, else acc unchanged.
    - Then mcand←mcand<<1; mplier←mplier>>1; count←count+1.
    - When count reaches WIDTH-1 at the edge (the final iteration): p←final acc value (the sum including this iteration); go to DONE.
  - DONE:
    - done=1, busy=1 for exactly one cycle.
    - Next edge → IDLE.
- Latency: start sampled at edge t → done=1 during the cycle after edge t+WIDTH. Back-to-back throughput is one result per WIDTH+2 cycles.
- start asserted while in CALC or DONE is ignored. Operands are not re-sampled.
- a/b may change freely after the accepting edge; the result uses the captured values.
- Width rule: the adder is 2*WIDTH bits with carry-in 0. The product always fits, so carry-out is discarded and overflow is impossible.
- p changes only on DONE entry and on reset.

Optional Feature:
- Macro: SEQ_MULT_EARLY_EXIT_EN.
- Defined: in CALC, if the shifted mplier value about to be written is 0, transition to DONE at that edge with p←final acc, regardless of count.
  - Iteration count = max(1, index of highest set bit of b + 1).
  - b=0 → done in the cycle after edge t+1.
- Undefined: always exactly WIDTH iterations, fixed latency.
- Product value is identical in both builds; only latency differs.

Decomposition:
- Package seq_mult_pkg: typedef enum logic [1:0] state_t {IDLE, CALC, DONE}. Synthesis note: state encoding binary.
- One sub-module: rca_adder_n #(N) — parametrised ripple-carry adder built from the existing full-adder structural cell.
  - Ports: a[N], b[N], cin, sum[N], cout.
  - Instantiated once with N=2*WIDTH.
- No other hierarchy.

Test Plan:
1. WIDTH=4, reset 2 cycles, start 1 cycle with a=3, b=5 → p=0x0F, single-cycle done 4 edges after start was sampled, busy high in between.
2. WIDTH=4, a=15, b=15 → p=0xE1 (225), no overflow; then a=1, b=1 → p=0x01, with p holding 0xE1 until the second done.
3. WIDTH=4, a=9, b=0 → p=0. Without the macro, done after 4 edges; with SEQ_MULT_EARLY_EXIT_EN, done after 1 edge.
4. WIDTH=4, a=3, b=5 accepted; start re-pulsed at the second CALC cycle with a=7, b=7 → result 15, second request ignored, busy never drops early.
5. WIDTH=4, a=6, b=7 accepted; reset asserted at the second CALC edge → busy=0, done never pulses, p=0. Next start with a=2, b=6 → p=12.
6. WIDTH=8, a=255, b=2 → p=510 (0x01FE). Without the macro, latency 8; with SEQ_MULT_EARLY_EXIT_EN, latency 2.
